// File: rtl/demux2_stream_pkg.sv
// Shared encodings and default sizes for the 1-to-2 stream demultiplexer.
package demux2_stream_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_ALT = 1'b1
    } mode_e;

endpackage

// File: rtl/demux2_slot.sv
// One-entry valid/ready holding register with a wrapping handshake counter.
module demux2_slot
    import demux2_stream_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             can_accept_c
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drain;

    // A slot draining this cycle can be refilled in the same cycle.
    assign can_accept_c = ~valid_q | ready_i;
    assign drain        = valid_q & ready_i;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q & ~ready_i;
        cnt_d   = cnt_q + CNT_W'(drain);
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/demux2_stream.sv
// Registered 1-to-2 stream demultiplexer: routes one valid/ready stream to Z0
// or Z1, steered by S or by automatic alternation.
module demux2_stream
    import demux2_stream_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             MODE,
    input  logic [WIDTH-1:0] I,
    input  logic             S,
    input  logic             I_VALID,
    output logic             I_READY,
    output logic [WIDTH-1:0] Z0,
    output logic             Z0_VALID,
    input  logic             Z0_READY,
    output logic [WIDTH-1:0] Z1,
    output logic             Z1_VALID,
    input  logic             Z1_READY,
    output logic [CNT_W-1:0] CNT0,
    output logic [CNT_W-1:0] CNT1
);

    mode_e mode;
    logic  alt_q, alt_d;
    logic  sel;
    logic  accept;
    logic  can0, can1;

    assign mode = mode_e'(MODE);
    assign sel  = (mode == MODE_ALT) ? alt_q : S;

    // Head-of-line blocking: only the selected slot decides readiness.
    assign I_READY = sel ? can1 : can0;
    assign accept  = I_VALID & I_READY;

    // Pointer is held at zero outside alternate mode so it restarts on Z0.
    always_comb begin
        alt_d = 1'b0;
        if (mode == MODE_ALT) begin
            alt_d = alt_q ^ accept;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            alt_q <= 1'b0;
        end else begin
            alt_q <= alt_d;
        end
    end

    demux2_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
        .clk          (CLK),
        .rst_n        (RN),
        .load_i       (accept & ~sel),
        .data_i       (I),
        .ready_i      (Z0_READY),
        .data_o       (Z0),
        .valid_o      (Z0_VALID),
        .cnt_o        (CNT0),
        .can_accept_c (can0)
    );

    demux2_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
        .clk          (CLK),
        .rst_n        (RN),
        .load_i       (accept & sel),
        .data_i       (I),
        .ready_i      (Z1_READY),
        .data_o       (Z1),
        .valid_o      (Z1_VALID),
        .cnt_o        (CNT1),
        .can_accept_c (can1)
    );

endmodule

// File: tb/tb_demux2_stream.sv
// Directed bench for demux2_stream built with 4-bit counters so wrap is reachable.
module tb_demux2_stream;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic          CLK = 1'b0;
    logic          RN = 1'b0;
    logic          MODE = 1'b0;
    logic [W-1:0]  I = '0;
    logic          S = 1'b0;
    logic          I_VALID = 1'b0;
    logic          I_READY;
    logic [W-1:0]  Z0, Z1;
    logic          Z0_VALID, Z1_VALID;
    logic          Z0_READY = 1'b0;
    logic          Z1_READY = 1'b0;
    logic [CW-1:0] CNT0, CNT1;

    int checks = 0;
    int failures = 0;

    demux2_stream #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLK      (CLK),
        .RN       (RN),
        .MODE     (MODE),
        .I        (I),
        .S        (S),
        .I_VALID  (I_VALID),
        .I_READY  (I_READY),
        .Z0       (Z0),
        .Z0_VALID (Z0_VALID),
        .Z0_READY (Z0_READY),
        .Z1       (Z1),
        .Z1_VALID (Z1_VALID),
        .Z1_READY (Z1_READY),
        .CNT0     (CNT0),
        .CNT1     (CNT1)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       mode, s, iv;
        logic [7:0] i;
        logic       z0r, z1r;
        logic       rdy;
        logic       z0v;
        logic [7:0] z0;
        logic       z1v;
        logic [7:0] z1;
        logic [3:0] c0, c1;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input int mode, input int s, input int iv, input int i,
                                input int z0r, input int z1r, input int rdy,
                                input int z0v, input int z0, input int z1v, input int z1,
                                input int c0, input int c1);
        vec_t v;
        v.mode = 1'(mode); v.s = 1'(s); v.iv = 1'(iv); v.i = 8'(i);
        v.z0r = 1'(z0r); v.z1r = 1'(z1r); v.rdy = 1'(rdy);
        v.z0v = 1'(z0v); v.z0 = 8'(z0); v.z1v = 1'(z1v); v.z1 = 8'(z1);
        v.c0 = 4'(c0); v.c1 = 4'(c1);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        MODE = 1'b0; S = 1'b0; I_VALID = 1'b0; I = '0;
        Z0_READY = 1'b0; Z1_READY = 1'b0;
    endtask

    // Leaves the bench aligned one time unit after a rising edge.
    task automatic do_reset();
        RN = 1'b0;
        idle_inputs();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RN = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Steer mode, full rate: odd beats to Z0, even beats to Z1.
        vq.push_back(mk(0,0,1,8'h01, 1,1, 1, 1,8'h01, 0,8'h00, 0,0));
        vq.push_back(mk(0,1,1,8'h02, 1,1, 1, 0,8'h01, 1,8'h02, 1,0));
        vq.push_back(mk(0,0,1,8'h03, 1,1, 1, 1,8'h03, 0,8'h02, 1,1));
        vq.push_back(mk(0,1,1,8'h04, 1,1, 1, 0,8'h03, 1,8'h04, 2,1));
        vq.push_back(mk(0,0,1,8'h05, 1,1, 1, 1,8'h05, 0,8'h04, 2,2));
        vq.push_back(mk(0,1,1,8'h06, 1,1, 1, 0,8'h05, 1,8'h06, 3,2));
        vq.push_back(mk(0,0,1,8'h07, 1,1, 1, 1,8'h07, 0,8'h06, 3,3));
        vq.push_back(mk(0,1,1,8'h08, 1,1, 1, 0,8'h07, 1,8'h08, 4,3));
        vq.push_back(mk(0,0,0,8'h00, 1,1, 1, 0,8'h07, 0,8'h08, 4,4));
        // Backpressure and head-of-line blocking on each channel.
        vq.push_back(mk(0,0,1,8'h11, 0,1, 1, 1,8'h11, 0,8'h08, 4,4));
        vq.push_back(mk(0,0,1,8'h22, 0,1, 0, 1,8'h11, 0,8'h08, 4,4));
        vq.push_back(mk(0,0,1,8'h22, 0,1, 0, 1,8'h11, 0,8'h08, 4,4));
        vq.push_back(mk(0,0,1,8'h22, 1,1, 1, 1,8'h22, 0,8'h08, 5,4));
        vq.push_back(mk(0,0,0,8'h00, 1,1, 1, 0,8'h22, 0,8'h08, 6,4));
        vq.push_back(mk(0,1,1,8'h33, 1,0, 1, 0,8'h22, 1,8'h33, 6,4));
        vq.push_back(mk(0,1,1,8'h44, 1,0, 0, 0,8'h22, 1,8'h33, 6,4));
        vq.push_back(mk(0,1,1,8'h44, 1,1, 1, 0,8'h22, 1,8'h44, 6,5));
        vq.push_back(mk(0,0,1,8'h55, 1,1, 1, 1,8'h55, 0,8'h44, 6,6));
        vq.push_back(mk(0,0,0,8'h00, 1,1, 1, 0,8'h55, 0,8'h44, 7,6));
        // Alternate mode with S tied high; then a MODE dip restarts on Z0.
        vq.push_back(mk(1,1,1,8'h30, 1,1, 1, 1,8'h30, 0,8'h44, 7,6));
        vq.push_back(mk(1,1,1,8'h31, 1,1, 1, 0,8'h30, 1,8'h31, 8,6));
        vq.push_back(mk(1,1,1,8'h32, 1,1, 1, 1,8'h32, 0,8'h31, 8,7));
        vq.push_back(mk(1,1,1,8'h33, 1,1, 1, 0,8'h32, 1,8'h33, 9,7));
        vq.push_back(mk(1,1,1,8'h34, 1,1, 1, 1,8'h34, 0,8'h33, 9,8));
        vq.push_back(mk(0,1,0,8'h00, 1,1, 1, 0,8'h34, 0,8'h33, 10,8));
        vq.push_back(mk(1,1,1,8'h35, 1,1, 1, 1,8'h35, 0,8'h33, 10,8));
        vq.push_back(mk(1,1,0,8'h00, 1,1, 1, 0,8'h35, 0,8'h33, 11,8));

        // Reset held with random inputs: everything zero, input ready.
        RN = 1'b0;
        @(posedge CLK);
        #1;
        for (int k = 0; k < 4; k++) begin
            MODE = 1'($urandom); S = 1'($urandom); I_VALID = 1'($urandom);
            I = 8'($urandom); Z0_READY = 1'($urandom); Z1_READY = 1'($urandom);
            #1;
            chk($sformatf("rst%0d outs", k), {Z0, Z1, 6'(Z0_VALID), 6'(Z1_VALID), 4'(CNT0), 4'(CNT1)}, 32'h0);
            chk($sformatf("rst%0d i_ready", k), 32'(I_READY), 32'h1);
            @(posedge CLK);
            #1;
        end
        RN = 1'b1;
        MODE = 1'b0; I = 8'hA5; S = 1'b1; I_VALID = 1'b1; Z0_READY = 1'b0; Z1_READY = 1'b0;
        #1;
        chk("first i_ready", 32'(I_READY), 32'h1);
        @(posedge CLK);
        #1;
        I_VALID = 1'b0;
        chk("first z1", 32'(Z1), 32'hA5);
        chk("first z1_valid", 32'(Z1_VALID), 32'h1);
        chk("first z0_valid", 32'(Z0_VALID), 32'h0);

        do_reset();
        foreach (vq[k]) begin
            MODE = vq[k].mode; S = vq[k].s; I_VALID = vq[k].iv; I = vq[k].i;
            Z0_READY = vq[k].z0r; Z1_READY = vq[k].z1r;
            #1;
            chk($sformatf("vec%0d i_ready", k), 32'(I_READY), 32'(vq[k].rdy));
            @(posedge CLK);
            #1;
            chk($sformatf("vec%0d z0_valid", k), 32'(Z0_VALID), 32'(vq[k].z0v));
            chk($sformatf("vec%0d z0", k), 32'(Z0), 32'(vq[k].z0));
            chk($sformatf("vec%0d z1_valid", k), 32'(Z1_VALID), 32'(vq[k].z1v));
            chk($sformatf("vec%0d z1", k), 32'(Z1), 32'(vq[k].z1));
            chk($sformatf("vec%0d cnt0", k), 32'(CNT0), 32'(vq[k].c0));
            chk($sformatf("vec%0d cnt1", k), 32'(CNT1), 32'(vq[k].c1));
        end

        // Counter wrap: 17 beats on Z1 through a 4-bit counter.
        do_reset();
        MODE = 1'b0; S = 1'b1; Z0_READY = 1'b1; Z1_READY = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            I = 8'(k); I_VALID = 1'b1;
            @(posedge CLK);
            #1;
        end
        I_VALID = 1'b0;
        @(posedge CLK);
        #1;
        chk("wrap cnt1", 32'(CNT1), 32'h1);
        chk("wrap cnt0", 32'(CNT0), 32'h0);
        chk("wrap z1 last", 32'(Z1), 32'h11);
        chk("wrap z1_valid", 32'(Z1_VALID), 32'h0);

        // Mid-operation asynchronous reset with both slots full and stalled.
        Z0_READY = 1'b0; Z1_READY = 1'b0;
        I = 8'h66; S = 1'b0; I_VALID = 1'b1;
        @(posedge CLK);
        #1;
        I = 8'h77; S = 1'b1;
        @(posedge CLK);
        #1;
        I_VALID = 1'b0;
        chk("full z0_valid", 32'(Z0_VALID), 32'h1);
        chk("full z1_valid", 32'(Z1_VALID), 32'h1);
        chk("full cnt1", 32'(CNT1), 32'h1);
        #2;
        RN = 1'b0;
        #1;
        chk("async z0_valid", 32'(Z0_VALID), 32'h0);
        chk("async z1_valid", 32'(Z1_VALID), 32'h0);
        chk("async cnts", {24'h0, CNT0, CNT1}, 32'h0);
        chk("async data", {16'h0, Z0, Z1}, 32'h0);
        #1;
        RN = 1'b1;
        Z0_READY = 1'b1; Z1_READY = 1'b1;
        @(posedge CLK);
        #1;
        chk("post z0_valid", 32'(Z0_VALID), 32'h0);
        chk("post z1_valid", 32'(Z1_VALID), 32'h0);
        chk("post cnts", {24'h0, CNT0, CNT1}, 32'h0);
        I = 8'h88; S = 1'b0; I_VALID = 1'b1;
        #1;
        chk("post i_ready", 32'(I_READY), 32'h1);
        @(posedge CLK);
        #1;
        I_VALID = 1'b0;
        chk("post z0", 32'(Z0), 32'h88);
        chk("post z0_valid2", 32'(Z0_VALID), 32'h1);
        chk("post z1_valid2", 32'(Z1_VALID), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux2_stream.md
Name: demux2_stream

Overview:
- Registered 1-to-2 stream demultiplexer; the inverse of the 2:1 mux. Routes one valid/ready input stream to output Z0 or Z1.
- Routing is either by per-beat select S or by automatic alternation.
- Each output has a one-entry holding register, so input-to-output latency is one cycle.
- Sits at the boundary between a shared datapath and two consumer channels in MCU-class logic.
- Per-channel transfer counters support debug and observation.

Parameters:
- WIDTH, 8, data width of I, Z0 and Z1.
- CNT_W, 8, width of the per-channel transfer counters.

Ports:
- CLK  input  1  rising-edge clock.
- RN  input  1  asynchronous active-low reset.
- MODE  input  1  0 = steer by S; 1 = alternate Z0, Z1, Z0, …
- I  input  WIDTH  input data.
- S  input  1  channel select, qualified by I_VALID; ignored when MODE=1.
- I_VALID  input  1  input beat valid.
- I_READY  output  1  input beat accepted this cycle.
- Z0  output  WIDTH  channel 0 data.
- Z0_VALID  output  1  channel 0 holds a beat.
- Z0_READY  input  1  channel 0 consumer accepts.
- Z1  output  WIDTH  channel 1 data.
- Z1_VALID  output  1  channel 1 holds a beat.
- Z1_READY  input  1  channel 1 consumer accepts.
- CNT0  output  CNT_W  beats delivered on Z0, wrapping.
- CNT1  output  CNT_W  beats delivered on Z1, wrapping.

Behaviour:
- Reset (RN low, asynchronous, any time): Z0 = Z1 = 0, Z0_VALID = Z1_VALID = 0, CNT0 = CNT1 = 0, alternation pointer ALT = 0.
  - A beat in flight is discarded.
  - The first cycle after RN deasserts behaves like a fresh start.
- Target channel:
  - sel = S when MODE=0.
  - sel = ALT when MODE=1.
- Acceptance:
  - I_READY = ~Zsel_VALID | Zsel_READY.
  - This is combinational from MODE, S, ALT, the slot state and Zsel_READY. There is no path from I_VALID to I_READY.
  - Accept = I_VALID & I_READY.
- On accept:
  - The selected slot loads I and sets VALID at the next CLK edge.
  - Latency is one cycle.
  - Zero-bubble throughput: a full slot that is draining in the same cycle can be reloaded that cycle.
- Drain:
  - When Zn_VALID & Zn_READY and no reload, Zn_VALID clears next edge.
  - Zn data holds its last value; it is not cleared.
- Output stability: while Zn_VALID=1 and Zn_READY=0, Zn and Zn_VALID must not change.
- No reordering or bypass:
  - If the selected slot is blocked, I_READY=0 even when the other slot is empty. This is head-of-line blocking by design.
- Alternation:
  - ALT toggles on every accept while MODE=1.
  - ALT is forced to 0 on any cycle where MODE=0, so entering MODE=1 always starts on Z0.
  - MODE is a quasi-static control. Changing it while a slot is full is legal and does not disturb held beats.
- Counters:
  - CNTn increments by 1 on each Zn_VALID & Zn_READY handshake.
  - CNTn wraps from 2^CNT_W-1 to 0 silently.
- Simultaneous events:
  - Accept into slot n together with drain of slot n: VALID stays 1 and data takes the new beat.
  - Accept into one slot and drain of the other in the same cycle are independent.
  - Both channels can drain in the same cycle; both counters increment.
- Outputs Z0 and Z1 are register-driven. The only combinational paths are to I_READY.

Decomposition:
- Shared package demux2_stream_pkg holds:
  - MODE encodings: MODE_SEL = 1'b0, MODE_ALT = 1'b1.
  - Default WIDTH and CNT_W constants.
- Natural sub-module: demux2_slot.
  - One-entry valid/ready holding register with load, drain and transfer counter.
  - Instantiated twice.
  - Exposes a "can_accept" output used to form I_READY.
- The top level holds only sel/ALT logic and the I_READY mux.

Test Plan:
- Reset: hold RN=0 with random inputs → all outputs 0, I_READY = 1. Release RN; I=0xA5, S=1, I_VALID=1 for one cycle → next cycle Z1=0xA5, Z1_VALID=1, Z0_VALID=0.
- Steer mode, full rate: MODE=0, Z0_READY = Z1_READY = 1, stream 0x01..0x08 with S = 0,1,0,1… → I_READY held 1; odd values on Z0 and even values on Z1, each one cycle later; CNT0 = CNT1 = 4.
- Backpressure and HOL blocking: MODE=0, Z0_READY=0, send 0x11 (S=0), then 0x22 (S=0) → I_READY=0 on the second beat; Z0 stays 0x11 with VALID=1. Raise Z0_READY → 0x22 accepted the same cycle and appears on Z0 next cycle, with no gap.
- Alternate mode: MODE=1, S tied to 1, send 0x30..0x33 → 0x30 and 0x32 on Z0, 0x31 and 0x33 on Z1. Drop MODE to 0 and back to 1 → the next beat goes to Z0.
- Counter wrap: CNT_W=4, deliver 17 beats on Z1 → CNT1 = 1, CNT0 = 0.
- Mid-operation reset: both slots full and stalled, pulse RN low between clock edges → Z0_VALID and Z1_VALID drop immediately (asynchronously); counters read 0; no stale beat appears after release.
